// File: rtl/pipe_hazard_pkg.sv
// Shared definitions for the D/X/M hazard controller: FSM encoding,
// forwarding-select codes and the pipeline bubble instruction.
package pipe_hazard_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        STALL     = 2'd1,
        STALL_RDR = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF = 2'd0;  // operand from register file
    localparam logic [1:0] FWD_X  = 2'd1;  // operand from X-stage ALU result
    localparam logic [1:0] FWD_M  = 2'd2;  // operand from M-stage writeback

    // addi x0,x0,0: injected into D/X when a redirect flushes them
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipe_hazard_fwd_unit.sv
// Per-operand hazard detection: picks the forwarding source for one source
// register and flags a load-use hazard that forwarding cannot cover.
module pipe_hazard_fwd_unit #(
    parameter int RA_W  = 5,
    parameter bit FWD_X = 1'b1
) (
    input  logic [RA_W-1:0] rs_addr_i,
    input  logic            rs_used_i,
    input  logic [RA_W-1:0] rd_addr_x_i,
    input  logic            rd_write_x_i,
    input  logic            d_re_x_i,
    input  logic [RA_W-1:0] rd_addr_m_i,
    input  logic            rd_write_m_i,
    output logic [1:0]      sel_o,
    output logic            load_use_o
);
    import pipe_hazard_pkg::*;

    logic hit_x;
    logic hit_m;

    // Match against X and M destinations; X is younger, so it takes priority.
    always_comb begin
        hit_x      = rs_used_i & (rs_addr_i != '0) & (rs_addr_i == rd_addr_x_i) & rd_write_x_i;
        hit_m      = rs_used_i & (rs_addr_i != '0) & (rs_addr_i == rd_addr_m_i) & rd_write_m_i;
        load_use_o = hit_x & (d_re_x_i | ~FWD_X);
        sel_o      = pipe_hazard_pkg::FWD_RF;
        if (hit_x & ~d_re_x_i & FWD_X) begin
            sel_o = pipe_hazard_pkg::FWD_X;
        end else if (hit_m) begin
            sel_o = pipe_hazard_pkg::FWD_M;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard/sequencing controller for the D/X/M pipeline: stall,
// interlock and redirect (flush) control, forwarding selects, perf counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32,
    parameter int RA_W  = 5,
    parameter bit FWD_X = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  rs1_addr_D,
    input  logic [RA_W-1:0]  rs2_addr_D,
    input  logic             rs1_used_D,
    input  logic             rs2_used_D,
    input  logic [RA_W-1:0]  rd_addr_X,
    input  logic             rd_write_X,
    input  logic             d_re_X,
    input  logic [RA_W-1:0]  rd_addr_M,
    input  logic             rd_write_M,
    input  logic             br_mispredict_X,
    input  logic [31:0]      redirect_pc_X,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    output logic             stall,
    output logic             interlock,
    output logic             taken,
    output logic [31:0]      redirect_pc,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_interlock,
    output logic [CNT_W-1:0] cnt_flush
);
    import pipe_hazard_pkg::*;

    state_e           state_q, state_d;
    logic [31:0]      rdr_pc_q, rdr_pc_d;
    logic [CNT_W-1:0] cnt_stall_q, cnt_interlock_q, cnt_flush_q;

    logic             stall_raw, taken_raw, interlock_raw;
    logic [31:0]      redirect_raw;
    logic [1:0]       sel_a, sel_b;
    logic             lu_a, lu_b;

    pipe_hazard_fwd_unit #(.RA_W(RA_W), .FWD_X(FWD_X)) u_fwd_a (
        .rs_addr_i    (rs1_addr_D),
        .rs_used_i    (rs1_used_D),
        .rd_addr_x_i  (rd_addr_X),
        .rd_write_x_i (rd_write_X),
        .d_re_x_i     (d_re_X),
        .rd_addr_m_i  (rd_addr_M),
        .rd_write_m_i (rd_write_M),
        .sel_o        (sel_a),
        .load_use_o   (lu_a)
    );

    pipe_hazard_fwd_unit #(.RA_W(RA_W), .FWD_X(FWD_X)) u_fwd_b (
        .rs_addr_i    (rs2_addr_D),
        .rs_used_i    (rs2_used_D),
        .rd_addr_x_i  (rd_addr_X),
        .rd_write_x_i (rd_write_X),
        .d_re_x_i     (d_re_X),
        .rd_addr_m_i  (rd_addr_M),
        .rd_write_m_i (rd_write_M),
        .sel_o        (sel_b),
        .load_use_o   (lu_b)
    );

    // Next-state logic: a redirect seen while stalled is latched once and
    // replayed as a single taken pulse when the stall releases.
    always_comb begin
        state_d  = state_q;
        rdr_pc_d = rdr_pc_q;
        unique case (state_q)
            RUN: begin
                if (stall_raw) begin
                    if (br_mispredict_X) begin
                        state_d  = STALL_RDR;
                        rdr_pc_d = redirect_pc_X;
                    end else begin
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                if (!stall_raw) begin
                    state_d = RUN;
                end else if (br_mispredict_X) begin
                    state_d  = STALL_RDR;
                    rdr_pc_d = redirect_pc_X;
                end
            end
            STALL_RDR: begin
                if (!stall_raw) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Pipeline controls; taken overrides interlock, stall overrides both.
    // Outputs read as idle while reset is applied.
    always_comb begin
        stall_raw     = icache_stall | dcache_stall;
        taken_raw     = ~stall_raw & (br_mispredict_X | (state_q == STALL_RDR));
        interlock_raw = ~stall_raw & ~taken_raw & (lu_a | lu_b);
        redirect_raw  = (state_q == STALL_RDR) ? rdr_pc_q : redirect_pc_X;

        stall       = ~rst & stall_raw;
        taken       = ~rst & taken_raw;
        interlock   = ~rst & interlock_raw;
        redirect_pc = rst ? '0 : redirect_raw;
        fwd_a_sel   = rst ? pipe_hazard_pkg::FWD_RF : sel_a;
        fwd_b_sel   = rst ? pipe_hazard_pkg::FWD_RF : sel_b;
    end

    // State, redirect latch and wrapping performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RUN;
            rdr_pc_q        <= '0;
            cnt_stall_q     <= '0;
            cnt_interlock_q <= '0;
            cnt_flush_q     <= '0;
        end else begin
            state_q  <= state_d;
            rdr_pc_q <= rdr_pc_d;
            if (stall_raw)     cnt_stall_q     <= cnt_stall_q + CNT_W'(1);
            if (interlock_raw) cnt_interlock_q <= cnt_interlock_q + CNT_W'(1);
            if (taken_raw)     cnt_flush_q     <= cnt_flush_q + CNT_W'(1);
        end
    end

    // Counter outputs straight from their registers.
    always_comb begin
        cnt_stall     = cnt_stall_q;
        cnt_interlock = cnt_interlock_q;
        cnt_flush     = cnt_flush_q;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: two controllers (X forwarding on/off) share inputs and
// are compared every cycle against a pending-redirect / hazard-rule model.
module tb_pipe_hazard_ctrl;

    localparam int CW   = 5;
    localparam int RA_W = 5;
    localparam int CMASK = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [RA_W-1:0] rs1_addr_D, rs2_addr_D, rd_addr_X, rd_addr_M;
    logic            rs1_used_D, rs2_used_D, rd_write_X, d_re_X, rd_write_M;
    logic            br_mispredict_X, icache_stall, dcache_stall;
    logic [31:0]     redirect_pc_X;

    logic            stall1, il1, tk1, stall0, il0, tk0;
    logic [31:0]     rpc1, rpc0;
    logic [1:0]      fa1, fb1, fa0, fb0;
    logic [CW-1:0]   cs1, ci1, cf1, cs0, ci0, cf0;

    int n_err = 0;
    int n_chk = 0;

    // model state
    bit          m_pend = 1'b0;
    logic [31:0] m_pend_pc = '0;
    int          m_cs = 0, m_ci1 = 0, m_ci0 = 0, m_cf = 0;

    // last observed values for directed checks
    logic        o_il1, o_il0, o_tk;
    logic [31:0] o_rpc;
    logic [1:0]  o_fa1, o_fb1;
    int          o_cs, o_cf;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CW), .RA_W(RA_W), .FWD_X(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
        .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
        .rd_addr_X(rd_addr_X), .rd_write_X(rd_write_X), .d_re_X(d_re_X),
        .rd_addr_M(rd_addr_M), .rd_write_M(rd_write_M),
        .br_mispredict_X(br_mispredict_X), .redirect_pc_X(redirect_pc_X),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .stall(stall1), .interlock(il1), .taken(tk1), .redirect_pc(rpc1),
        .fwd_a_sel(fa1), .fwd_b_sel(fb1),
        .cnt_stall(cs1), .cnt_interlock(ci1), .cnt_flush(cf1)
    );

    pipe_hazard_ctrl #(.CNT_W(CW), .RA_W(RA_W), .FWD_X(1'b0)) u_dut0 (
        .clk(clk), .rst(rst),
        .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
        .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
        .rd_addr_X(rd_addr_X), .rd_write_X(rd_write_X), .d_re_X(d_re_X),
        .rd_addr_M(rd_addr_M), .rd_write_M(rd_write_M),
        .br_mispredict_X(br_mispredict_X), .redirect_pc_X(redirect_pc_X),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .stall(stall0), .interlock(il0), .taken(tk0), .redirect_pc(rpc0),
        .fwd_a_sel(fa0), .fwd_b_sel(fb0),
        .cnt_stall(cs0), .cnt_interlock(ci0), .cnt_flush(cf0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input logic used, input logic [RA_W-1:0] rs,
                               input logic [RA_W-1:0] rd, input logic wr);
        return used && rs != 0 && rs == rd && wr;
    endfunction

    // Source chosen for one operand under the forwarding rules.
    function automatic logic [1:0] sel_of(input logic used, input logic [RA_W-1:0] rs, input bit fx);
        if (hit(used, rs, rd_addr_X, rd_write_X) && !d_re_X && fx) return 2'd1;
        if (hit(used, rs, rd_addr_M, rd_write_M)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit lu_of(input logic used, input logic [RA_W-1:0] rs, input bit fx);
        return hit(used, rs, rd_addr_X, rd_write_X) && (d_re_X || !fx);
    endfunction

    function automatic logic [31:0] cnt32(input logic [CW-1:0] c);
        return 32'(c);
    endfunction

    // One clock cycle: inputs already applied after negedge; check, then advance model.
    task automatic cyc();
        bit          e_st, e_tk, e_il1, e_il0;
        logic [31:0] e_rpc;
        logic [1:0]  e_fa1, e_fb1, e_fa0, e_fb0;
        #1;
        e_st  = icache_stall || dcache_stall;
        e_tk  = !e_st && (br_mispredict_X || m_pend);
        e_rpc = m_pend ? m_pend_pc : redirect_pc_X;
        e_il1 = !e_st && !e_tk && (lu_of(rs1_used_D, rs1_addr_D, 1) || lu_of(rs2_used_D, rs2_addr_D, 1));
        e_il0 = !e_st && !e_tk && (lu_of(rs1_used_D, rs1_addr_D, 0) || lu_of(rs2_used_D, rs2_addr_D, 0));
        e_fa1 = sel_of(rs1_used_D, rs1_addr_D, 1);
        e_fb1 = sel_of(rs2_used_D, rs2_addr_D, 1);
        e_fa0 = sel_of(rs1_used_D, rs1_addr_D, 0);
        e_fb0 = sel_of(rs2_used_D, rs2_addr_D, 0);
        if (rst) begin
            e_st = 0; e_tk = 0; e_il1 = 0; e_il0 = 0; e_rpc = '0;
            e_fa1 = 0; e_fb1 = 0; e_fa0 = 0; e_fb0 = 0;
        end
        chk("stall",       32'(stall1), 32'(e_st));
        chk("taken",       32'(tk1),    32'(e_tk));
        chk("redirect_pc", rpc1,        e_rpc);
        chk("interlock",   32'(il1),    32'(e_il1));
        chk("fwd_a",       32'(fa1),    32'(e_fa1));
        chk("fwd_b",       32'(fb1),    32'(e_fb1));
        chk("cnt_stall",   cnt32(cs1),  32'(m_cs));
        chk("cnt_intlk",   cnt32(ci1),  32'(m_ci1));
        chk("cnt_flush",   cnt32(cf1),  32'(m_cf));
        chk("nf_stall",    32'(stall0), 32'(e_st));
        chk("nf_taken",    32'(tk0),    32'(e_tk));
        chk("nf_rpc",      rpc0,        e_rpc);
        chk("nf_intlk",    32'(il0),    32'(e_il0));
        chk("nf_fwd_a",    32'(fa0),    32'(e_fa0));
        chk("nf_fwd_b",    32'(fb0),    32'(e_fb0));
        chk("nf_cnt_st",   cnt32(cs0),  32'(m_cs));
        chk("nf_cnt_il",   cnt32(ci0),  32'(m_ci0));
        chk("nf_cnt_fl",   cnt32(cf0),  32'(m_cf));
        o_il1 = il1; o_il0 = il0; o_tk = tk1; o_rpc = rpc1;
        o_fa1 = fa1; o_fb1 = fb1; o_cs = int'(cs1); o_cf = int'(cf1);
        @(posedge clk);
        if (rst) begin
            m_pend = 0; m_pend_pc = '0;
            m_cs = 0; m_ci1 = 0; m_ci0 = 0; m_cf = 0;
        end else begin
            if (e_st) begin
                if (br_mispredict_X && !m_pend) begin
                    m_pend = 1; m_pend_pc = redirect_pc_X;
                end
            end else begin
                m_pend = 0;
            end
            m_cs  = (m_cs  + int'(e_st))  & CMASK;
            m_ci1 = (m_ci1 + int'(e_il1)) & CMASK;
            m_ci0 = (m_ci0 + int'(e_il0)) & CMASK;
            m_cf  = (m_cf  + int'(e_tk))  & CMASK;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rs1_addr_D = '0; rs2_addr_D = '0; rs1_used_D = 0; rs2_used_D = 0;
        rd_addr_X = '0; rd_write_X = 0; d_re_X = 0;
        rd_addr_M = '0; rd_write_M = 0;
        br_mispredict_X = 0; redirect_pc_X = '0;
        icache_stall = 0; dcache_stall = 0;
    endtask

    initial begin
        int cs_base, cf_base;
        idle_inputs();
        // reset while both caches stall and a mispredict is requested
        rst = 1; icache_stall = 1; dcache_stall = 1; br_mispredict_X = 1;
        redirect_pc_X = 32'hDEAD_BEE0;
        @(posedge clk); @(negedge clk);
        cyc();
        chk("rst_taken", 32'(o_tk), 32'd0);
        chk("rst_cnt_stall", 32'(o_cs), 32'd0);

        // lw x5 in X, add x6,x5,x1 in D
        idle_inputs(); rst = 0;
        rd_addr_X = 5'd5; rd_write_X = 1; d_re_X = 1;
        rs1_addr_D = 5'd5; rs1_used_D = 1; rs2_addr_D = 5'd1; rs2_used_D = 1;
        cyc();
        chk("lu_interlock", 32'(o_il1), 32'd1);
        rd_addr_X = '0; rd_write_X = 0; d_re_X = 0;
        rd_addr_M = 5'd5; rd_write_M = 1;
        cyc();
        chk("lu_release_il", 32'(o_il1), 32'd0);
        chk("lu_fwd_a_m", 32'(o_fa1), 32'd2);

        // add x5 in X, sub uses x5 on rs2
        idle_inputs();
        rd_addr_X = 5'd5; rd_write_X = 1;
        rs1_addr_D = 5'd2; rs1_used_D = 1; rs2_addr_D = 5'd5; rs2_used_D = 1;
        rd_addr_M = 5'd5; rd_write_M = 1;
        cyc();
        chk("alu_fwd_b_x", 32'(o_fb1), 32'd1);
        chk("alu_no_il", 32'(o_il1), 32'd0);
        chk("nofwd_il", 32'(o_il0), 32'd1);
        // x0 never forwarded
        idle_inputs();
        rd_addr_X = '0; rd_write_X = 1; rd_addr_M = '0; rd_write_M = 1;
        rs1_used_D = 1; rs2_used_D = 1;
        cyc();
        chk("x0_fwd_a", 32'(o_fa1), 32'd0);
        chk("x0_fwd_b", 32'(o_fb1), 32'd0);

        // four-cycle D$ stall with a mispredict in stall cycle 2
        idle_inputs();
        cs_base = m_cs; cf_base = m_cf;
        for (int unsigned i = 0; i < 4; i++) begin
            dcache_stall = 1;
            br_mispredict_X = (i >= 1);
            redirect_pc_X = (i == 1) ? 32'h0000_0100 : 32'h0000_0200;
            cyc();
            chk("stall_no_taken", 32'(o_tk), 32'd0);
        end
        dcache_stall = 0; br_mispredict_X = 1; redirect_pc_X = 32'h0000_0200;
        cyc();
        chk("rel_taken", 32'(o_tk), 32'd1);
        chk("rel_pc", o_rpc, 32'h0000_0100);
        idle_inputs();
        cyc();
        chk("rel_one_pulse", 32'(o_tk), 32'd0);
        chk("stall_cnt_delta", 32'((o_cs - cs_base) & CMASK), 32'd4);
        chk("flush_cnt_delta", 32'((o_cf - cf_base) & CMASK), 32'd1);

        // mispredict together with load-use, unstalled
        idle_inputs();
        rd_addr_X = 5'd7; rd_write_X = 1; d_re_X = 1;
        rs1_addr_D = 5'd7; rs1_used_D = 1;
        br_mispredict_X = 1; redirect_pc_X = 32'h0000_0400;
        cyc();
        chk("br_lu_taken", 32'(o_tk), 32'd1);
        chk("br_lu_no_il", 32'(o_il1), 32'd0);

        // reset while a redirect is latched
        idle_inputs();
        icache_stall = 1; br_mispredict_X = 1; redirect_pc_X = 32'h0000_0800;
        cyc();
        br_mispredict_X = 0;
        cyc();
        rst = 1;
        cyc();
        rst = 0; icache_stall = 0;
        cyc();
        chk("rst_drops_rdr", 32'(o_tk), 32'd0);

        // stall counter wraps at 2^CW
        idle_inputs();
        rst = 1; cyc(); rst = 0;
        icache_stall = 1;
        for (int unsigned i = 0; i < (1 << CW) - 1; i++) cyc();
        cyc();
        chk("cnt_at_max", 32'(o_cs), 32'(CMASK));
        cyc();
        chk("cnt_wrapped", 32'(o_cs), 32'd0);

        // randomized traffic over a small register range to provoke hazards
        for (int unsigned i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            rs1_addr_D = 5'($urandom_range(0, 3));
            rs2_addr_D = 5'($urandom_range(0, 3));
            rs1_used_D = 1'($urandom);
            rs2_used_D = 1'($urandom);
            rd_addr_X = 5'($urandom_range(0, 3));
            rd_write_X = 1'($urandom);
            d_re_X = 1'($urandom);
            rd_addr_M = 5'($urandom_range(0, 3));
            rd_write_M = 1'($urandom);
            br_mispredict_X = ($urandom_range(0, 99) < 20);
            redirect_pc_X = $urandom & 32'hFFFF_FFFC;
            icache_stall = ($urandom_range(0, 99) < 20);
            dcache_stall = ($urandom_range(0, 99) < 20);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
